// File: rtl/input_debounce.sv
// input_debounce: per-bit debouncer for bouncing board switches/buttons.
// Each raw pin is double-flopped. After a post-reset settle window the
// debounced level only follows a new value that has been held for STABLE
// cycles. Accepted edges produce one-cycle rise/fall pulses.
// Optional build macro: INPUT_DEBOUNCE_INVERT_EN inverts raw_in ahead of the
// synchronizer, for active-low switches.
//
// state       | meaning
// ST_SETTLING | post-reset window; level_out tracks sync2, no pulses, settled=0
// ST_RUN      | normal debouncing; settled=1 until the next reset
module input_debounce #(
  parameter int WIDTH  = 8,
  parameter int STABLE = 262144
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out,
  output logic             settled
);

  localparam int             CW = $clog2(STABLE);
  localparam logic [CW-1:0] TC = CW'(STABLE - 1);

  typedef enum logic {
    ST_SETTLING = 1'b0,
    ST_RUN      = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [WIDTH-1:0]         w_raw;
  logic [WIDTH-1:0]         r_sync1;
  logic [WIDTH-1:0]         r_sync2;
  logic [WIDTH-1:0]         r_level;
  logic [WIDTH-1:0]         r_rise;
  logic [WIDTH-1:0]         r_fall;
  logic [WIDTH-1:0]         w_level_nxt;
  logic [WIDTH-1:0]         w_rise_nxt;
  logic [WIDTH-1:0]         w_fall_nxt;
  logic [WIDTH-1:0][CW-1:0] r_cnt;
  logic [WIDTH-1:0][CW-1:0] w_cnt_nxt;
  logic [CW-1:0]            r_settle_cnt;
  logic [CW-1:0]            w_settle_nxt;
  logic                     r_settled;

`ifdef INPUT_DEBOUNCE_INVERT_EN
  assign w_raw = ~raw_in;
`else
  assign w_raw = raw_in;
`endif

  // Two-flop synchronizer on the (optionally inverted) board pins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state, settle counter and registered settled flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_SETTLING;
      r_settle_cnt <= '0;
      r_settled    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_settled    <= (w_state_nxt == ST_RUN);
    end
  end

  // Next state: leave SETTLING once the settle counter hits its terminal count.
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    case (r_state)
      ST_SETTLING: begin
        if (r_settle_cnt == TC) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_settle_nxt = r_settle_cnt + CW'(1);
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_SETTLING;
      end
    endcase
  end

  // Per-bit acceptance: count cycles of disagreement, accept at terminal count.
  always_comb begin
    w_level_nxt = r_level;
    w_rise_nxt  = '0;
    w_fall_nxt  = '0;
    w_cnt_nxt   = '0;
    if (r_state == ST_SETTLING) begin
      w_level_nxt = r_sync2;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] < TC) begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end else begin
          // Counter is left at zero by the default above.
          w_level_nxt[i] = r_sync2[i];
          w_rise_nxt[i]  = r_sync2[i];
          w_fall_nxt[i]  = ~r_sync2[i];
        end
      end
    end
  end

  // Debounced level, per-bit counters and edge pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_level <= '0;
      r_cnt   <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_level <= w_level_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign level_out = r_level;
  assign rise_out  = r_rise;
  assign fall_out  = r_fall;
  assign settled   = r_settled;

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce (WIDTH=4, STABLE=4). Expected acceptances are
// queued when stimulus is driven and compared on the cycle they fall due;
// every other cycle must show no pulse and an unchanged level.
module tb_input_debounce;

  localparam int W  = 4;
  localparam int ST = 4;
`ifdef INPUT_DEBOUNCE_INVERT_EN
  localparam logic [W-1:0] INV = 4'b1111;
`else
  localparam logic [W-1:0] INV = 4'b0000;
`endif

  typedef struct {
    int           at;
    logic [W-1:0] lvl;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } sb_t;

  logic         clk;
  logic         resetn;
  logic [W-1:0] raw_in;
  logic [W-1:0] level_out;
  logic [W-1:0] rise_out;
  logic [W-1:0] fall_out;
  logic         settled;

  sb_t          q[$];
  int           cyc;
  int           n_vec;
  int           n_err;
  logic [W-1:0] exp_level;
  logic [W-1:0] rst_level;
  logic [W-1:0] sb_level;
  bit           fin_chk;

  input_debounce #(.WIDTH(W), .STABLE(ST)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_out  (rise_out),
    .fall_out  (fall_out),
    .settled   (settled)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  // Edges since the last reset release.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    sb_t e;
    if (!resetn) begin
      exp_level <= rst_level;
      chk("rst_out", 32'({level_out, rise_out, fall_out, settled}), 32'd0);
    end else begin
      chk("settled", 32'(settled), 32'(cyc >= ST));
      if (q.size() > 0 && q[0].at < cyc) begin
        e = q.pop_front();
        chk("sb_late", 32'(e.at), 32'(cyc));
      end
      if (q.size() > 0 && q[0].at == cyc) begin
        e = q.pop_front();
        chk("accept", 32'({level_out, rise_out, fall_out}), 32'({e.lvl, e.rise, e.fall}));
        exp_level <= e.lvl;
      end else begin
        if (cyc >= 3) chk("level", 32'(level_out), 32'(exp_level));
        chk("pulse", 32'({rise_out, fall_out}), 32'd0);
      end
    end
    if (fin_chk) chk("sb_drain", 32'(q.size()), 32'd0);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // New raw value sampled at the next edge k; if held, acceptance lands at k+1+ST.
  task automatic step_raw(input logic [W-1:0] v, input bit accept);
    sb_t e;
    @(posedge clk);
    #1;
    raw_in = v;
    if (accept) begin
      e.at   = cyc + 1 + 1 + ST;
      e.lvl  = v ^ INV;
      e.rise = e.lvl & ~sb_level;
      e.fall = ~e.lvl & sb_level;
      q.push_back(e);
      sb_level = e.lvl;
    end
  endtask

  task automatic do_reset(input logic [W-1:0] v);
    @(posedge clk);
    #1;
    raw_in    = v;
    rst_level = v ^ INV;
    sb_level  = rst_level;
    resetn    = 1'b0;
    idle(3);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    fin_chk   = 1'b0;
    raw_in    = 4'b1010;
    rst_level = 4'b1010 ^ INV;
    sb_level  = rst_level;
    resetn    = 1'b0;
    idle(3);
    #1;
    resetn = 1'b1;
    idle(8);

    // Single rising bit.
    step_raw(4'b1011, 1'b1);
    idle(8);

    // Two-cycle glitch on bit1 must be ignored, then a real fall is accepted on time.
    step_raw(4'b1001, 1'b0);
    idle(1);
    step_raw(4'b1011, 1'b0);
    idle(8);
    step_raw(4'b1001, 1'b1);
    idle(8);

    // Simultaneous rise on bit2 and fall on bit3.
    step_raw(4'b0101, 1'b1);
    idle(8);

    // Every bit flips at once.
    step_raw(4'b1010, 1'b1);
    idle(8);

    // Held one cycle short of acceptance: counter reaches terminal count, no accept.
    step_raw(4'b1011, 1'b0);
    idle(2);
    step_raw(4'b1010, 1'b0);
    idle(8);

    // Held exactly long enough, then reverted: two acceptances.
    step_raw(4'b1011, 1'b1);
    idle(3);
    step_raw(4'b1010, 1'b1);
    idle(12);

    // Reset while bit0 counter is at 2: no residual pulse, level re-tracks raw.
    step_raw(4'b1011, 1'b0);
    idle(4);
    #1;
    rst_level = 4'b1011 ^ INV;
    sb_level  = rst_level;
    resetn    = 1'b0;
    idle(3);
    #1;
    resetn = 1'b1;
    idle(10);

    // All-zero raw held through reset, then normal operation resumes.
    do_reset(4'b0000);
    idle(10);
    step_raw(4'b0001, 1'b1);
    idle(8);

    @(posedge clk);
    #1;
    fin_chk = 1'b1;
    @(negedge clk);
    #1;
    fin_chk = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
